seq_pattern_tx: RTL

//  Serial pattern generator: the transmit-side counterpart of the 1010 sequence detectors.
//  - Latches a PAT_W-bit pattern and a repeat count on start.
//  - Emits the pattern MSB-first, one bit per clk, repeated back-to-back with no gap bits.
//  - Drives detector benches and serial-link stimulus; a done pulse marks the end of the burst.

---
 rtl/seq_pkg.sv | 15 +
 rtl/seq_shift_reg.sv | 35 +++
 rtl/seq_pattern_tx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// The state enum carries PAR even when the parity build option is off.
package seq_pkg;

  localparam int PAT_W_DEF = 4;
  localparam logic [PAT_W_DEF-1:0] PAT_DEF_C = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_shift_reg.sv
// Load/shift register presenting its MSB; zeros shift in at the LSB.
// The transmitter loads it with the bits still to be sent after the current one.
module seq_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_val,
  output logic         msb
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (shift) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeat_cnt times, then pulses done.
// Build option SEQ_PATTERN_TX_PARITY_EN appends an even-parity bit after every repetition.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_DEF = PAT_DEF_C
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_def,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             ready,
  output logic             d,
  output logic             d_valid,
  output logic             last,
  output logic             done
);

  localparam int               IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] pat_sel;
  logic             ready_q, ready_d;
  logic             d_q, d_d;
  logic             dv_q, dv_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             sr_load, sr_shift, sr_msb;
  logic [PAT_W-1:0] sr_val;
  logic             end_rep;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign pat_sel = use_def ? PAT_DEF : pattern_in;

  seq_shift_reg #(.W(PAT_W)) u_sr (
    .clk      (clk),
    .reset    (reset),
    .load     (sr_load),
    .shift    (sr_shift),
    .load_val (sr_val),
    .msb      (sr_msb)
  );

  always_comb begin
    state_d  = state_q;
    rep_d    = rep_q;
    idx_d    = idx_q;
    pat_d    = pat_q;
    ready_d  = 1'b0;
    d_d      = 1'b0;
    dv_d     = 1'b0;
    last_d   = 1'b0;
    done_d   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_val   = {pat_q[PAT_W-2:0], 1'b0};
    end_rep  = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    par_d    = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          pat_d   = pat_sel;
          rep_d   = repeat_cnt;
          ready_d = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
          par_d   = ^pat_sel;
`endif
          if (repeat_cnt == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SHIFT;
            idx_d   = IDX_TOP;
            sr_load = 1'b1;
            sr_val  = {pat_sel[PAT_W-2:0], 1'b0};
            d_d     = pat_sel[PAT_W-1];
            dv_d    = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          rep_d   = '0;
          idx_d   = '0;
        end else if (idx_q != '0) begin
          sr_shift = 1'b1;
          idx_d    = idx_q - 1'b1;
          d_d      = sr_msb;
          dv_d     = 1'b1;
`ifndef SEQ_PATTERN_TX_PARITY_EN
          last_d   = (idx_q == IDX_W'(1)) && (rep_q == ONE);
`endif
        end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
          state_d = ST_PAR;
          d_d     = par_q;
          dv_d    = 1'b1;
          last_d  = (rep_q == ONE);
`else
          end_rep = 1'b1;
`endif
        end
      end

`ifdef SEQ_PATTERN_TX_PARITY_EN
      ST_PAR: begin
        if (abort) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          rep_d   = '0;
          idx_d   = '0;
        end else begin
          end_rep = 1'b1;
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase

    // The remaining-repetition check happens before the decrement, so rep never wraps.
    if (end_rep) begin
      if (rep_q > ONE) begin
        state_d = ST_SHIFT;
        rep_d   = rep_q - ONE;
        idx_d   = IDX_TOP;
        sr_load = 1'b1;
        d_d     = pat_q[PAT_W-1];
        dv_d    = 1'b1;
      end else begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        rep_d   = '0;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rep_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      ready_q <= 1'b1;
      d_q     <= 1'b0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      ready_q <= ready_d;
      d_q     <= d_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign ready   = ready_q;
  assign d       = d_q;
  assign d_valid = dv_q;
  assign last    = last_q;
  assign done    = done_q;

endmodule
